// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan bus: segment codes, decoded digit
// markers, enable idle pattern and the receiver FSM state encoding.
package seg_pkg;

  localparam int NUM_DIG = 6;

  // Segment order is {a,b,c,d,e,f,g}, active-high.
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1110011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] DIG_BLANK = 4'hF;
  localparam logic [3:0] DIG_BAD   = 4'hE;

  localparam logic [5:0] ENB_NONE  = 6'b111111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } rx_state_e;

endpackage

// File: rtl/seg_code_dec.sv
// Inverse 7-segment decoder: segment code to BCD digit plus a bad-code flag.
// The all-off code decodes to the blank marker and is not an error.
module seg_code_dec
  import seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] digit_o,
  output logic       bad_o
);

  always_comb begin
    digit_o = DIG_BAD;
    bad_o   = 1'b0;
    case (seg_i)
      SEG_0:     digit_o = 4'd0;
      SEG_1:     digit_o = 4'd1;
      SEG_2:     digit_o = 4'd2;
      SEG_3:     digit_o = 4'd3;
      SEG_4:     digit_o = 4'd4;
      SEG_5:     digit_o = 4'd5;
      SEG_6:     digit_o = 4'd6;
      SEG_7:     digit_o = 4'd7;
      SEG_8:     digit_o = 4'd8;
      SEG_9:     digit_o = 4'd9;
      SEG_BLANK: digit_o = DIG_BLANK;
      default: begin
        digit_o = DIG_BAD;
        bad_o   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_rx.sv
// Scan-bus receiver: synchronizes and debounces the 6-digit display bus,
// reassembles a frame in a shadow and commits it atomically. SEG_SCAN_RX_DP_EN adds dp capture.
//
// state | meaning
// IDLE  | waiting for digit 0 to start a frame
// SCAN  | collecting digits in order, exp_idx is the next expected digit
module seg_scan_rx
  import seg_pkg::*;
#(
  parameter int SETTLE_CYC = 8,
  parameter int FRAME_TO   = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  i_seg_enb,
  input  logic [6:0]  i_seg,
  input  logic        i_seg_dp,
  output logic [23:0] o_digits,
  output logic [5:0]  o_dps,
  output logic        o_frame_vld,
  output logic [5:0]  o_dig_err,
  output logic        o_scan_err,
  output logic        o_timeout
);

`ifdef SEG_SCAN_RX_DP_EN
  localparam int SW = 14;
`else
  localparam int SW = 13;
`endif
  localparam int SCW = $clog2(SETTLE_CYC + 1);
  localparam int TOW = $clog2(FRAME_TO + 1);
  // Reset the sample pipe to the idle bus so no spurious accept follows reset.
  localparam logic [SW-1:0] SMP_RST = SW'({ENB_NONE, SEG_BLANK});

  logic [SW-1:0]  smp_raw;
  logic [SW-1:0]  sync1_q, sync2_q, prev_q;
  logic [SCW-1:0] stab_cnt_q, stab_cnt_d;
  logic           accept;

`ifdef SEG_SCAN_RX_DP_EN
  assign smp_raw = {i_seg_dp, i_seg_enb, i_seg};
`else
  logic unused_dp;
  assign unused_dp = i_seg_dp;
  assign smp_raw   = {i_seg_enb, i_seg};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= SMP_RST;
      sync2_q    <= SMP_RST;
      prev_q     <= SMP_RST;
      stab_cnt_q <= '0;
    end else begin
      sync1_q    <= smp_raw;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      stab_cnt_q <= stab_cnt_d;
    end
  end

  always_comb begin
    stab_cnt_d = stab_cnt_q;
    if (sync2_q != prev_q) begin
      stab_cnt_d = '0;
    end else if (stab_cnt_q != SCW'(SETTLE_CYC)) begin
      stab_cnt_d = stab_cnt_q + 1'b1;
    end
  end

  // Counter saturates one past the accept value, so accept fires once per dwell.
  assign accept = (sync2_q == prev_q) && (stab_cnt_q == SCW'(SETTLE_CYC - 1));

  logic [6:0] smp_seg;
  logic [5:0] smp_enb;
  logic [5:0] enb_low;
  logic       enb_blank, enb_onehot;
  logic [2:0] dig_k;
  logic       dig_acc, ill_acc;
  logic [3:0] dec_dig;
  logic       dec_bad;

  assign smp_seg    = sync2_q[6:0];
  assign smp_enb    = sync2_q[12:7];
  assign enb_low    = ~smp_enb;
  assign enb_blank  = (smp_enb == ENB_NONE);
  assign enb_onehot = (enb_low != 6'd0) && ((enb_low & (enb_low - 6'd1)) == 6'd0);
  assign dig_acc    = accept && enb_onehot;
  assign ill_acc    = accept && !enb_blank && !enb_onehot;

  always_comb begin
    dig_k = '0;
    for (int i = NUM_DIG - 1; i >= 0; i--) begin
      if (enb_low[i]) dig_k = 3'(i);
    end
  end

  seg_code_dec u_dec (
    .seg_i   (smp_seg),
    .digit_o (dec_dig),
    .bad_o   (dec_bad)
  );

  logic [TOW-1:0] to_cnt_q, to_cnt_d;
  logic           to_hit;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (dig_acc) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TOW'(FRAME_TO)) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  assign to_hit = !dig_acc && (to_cnt_q == TOW'(FRAME_TO - 1));

  rx_state_e  state_q, state_d;
  logic [2:0] exp_idx_q, exp_idx_d;
  logic       wr_en, shadow_clr, scan_err_d, commit_d;

  always_comb begin
    state_d    = state_q;
    exp_idx_d  = exp_idx_q;
    wr_en      = 1'b0;
    shadow_clr = 1'b0;
    scan_err_d = 1'b0;
    commit_d   = 1'b0;
    if (dig_acc) begin
      case (state_q)
        ST_IDLE: begin
          if (dig_k == 3'd0) begin
            wr_en     = 1'b1;
            exp_idx_d = 3'd1;
            state_d   = ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (dig_k == exp_idx_q) begin
            wr_en = 1'b1;
            if (dig_k == 3'(NUM_DIG - 1)) begin
              commit_d  = 1'b1;
              exp_idx_d = 3'd0;
              state_d   = ST_IDLE;
            end else begin
              exp_idx_d = exp_idx_q + 3'd1;
            end
          end else if (dig_k == exp_idx_q - 3'd1) begin
            wr_en = 1'b1;
          end else begin
            scan_err_d = 1'b1;
            shadow_clr = 1'b1;
            if (dig_k == 3'd0) begin
              wr_en     = 1'b1;
              exp_idx_d = 3'd1;
              state_d   = ST_SCAN;
            end else begin
              exp_idx_d = 3'd0;
              state_d   = ST_IDLE;
            end
          end
        end
        default: begin
          exp_idx_d = 3'd0;
          state_d   = ST_IDLE;
        end
      endcase
    end else if (ill_acc) begin
      scan_err_d = 1'b1;
      shadow_clr = 1'b1;
      exp_idx_d  = 3'd0;
      state_d    = ST_IDLE;
    end else if (to_hit) begin
      exp_idx_d = 3'd0;
      state_d   = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      exp_idx_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      exp_idx_q <= exp_idx_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  logic [23:0] shadow_dig_q;
  logic [5:0]  shadow_err_q;
  logic        commit_q;
  logic [23:0] digits_q;
  logic [5:0]  dig_err_q;
  logic        frame_vld_q, scan_err_q, timeout_q;

  // A clear and a digit-0 write may coincide on a restart; the write wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_dig_q <= '0;
      shadow_err_q <= '0;
    end else begin
      if (shadow_clr) begin
        shadow_dig_q <= '0;
        shadow_err_q <= '0;
      end
      if (wr_en) begin
        shadow_dig_q[dig_k*4 +: 4] <= dec_dig;
        shadow_err_q[dig_k]        <= dec_bad;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_q    <= 1'b0;
      digits_q    <= '0;
      dig_err_q   <= '0;
      frame_vld_q <= 1'b0;
      scan_err_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      commit_q    <= commit_d;
      frame_vld_q <= commit_q;
      scan_err_q  <= scan_err_d;
      if (commit_q) begin
        digits_q  <= shadow_dig_q;
        dig_err_q <= shadow_err_q;
        timeout_q <= 1'b0;
      end else if (to_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

`ifdef SEG_SCAN_RX_DP_EN
  logic [5:0] shadow_dp_q, dps_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_dp_q <= '0;
      dps_q       <= '0;
    end else begin
      if (shadow_clr) shadow_dp_q <= '0;
      if (wr_en) shadow_dp_q[dig_k] <= sync2_q[13];
      if (commit_q) dps_q <= shadow_dp_q;
    end
  end

  assign o_dps = dps_q;
`else
  assign o_dps = 6'd0;
`endif

  assign o_digits    = digits_q;
  assign o_dig_err   = dig_err_q;
  assign o_frame_vld = frame_vld_q;
  assign o_scan_err  = scan_err_q;
  assign o_timeout   = timeout_q;

endmodule
